// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU op bit positions,
// memory access size codes, divide-capture states and the ID->EX payload layout.
package exe_stage_pkg;

  localparam int unsigned DS_TO_ES_BUS_WD = 158;
  localparam int unsigned ES_TO_MS_BUS_WD = 74;
  localparam int unsigned ALU_OP_WD       = 19;

  localparam int unsigned ALU_ADD   = 0;
  localparam int unsigned ALU_SUB   = 1;
  localparam int unsigned ALU_SLT   = 2;
  localparam int unsigned ALU_SLTU  = 3;
  localparam int unsigned ALU_AND   = 4;
  localparam int unsigned ALU_NOR   = 5;
  localparam int unsigned ALU_OR    = 6;
  localparam int unsigned ALU_XOR   = 7;
  localparam int unsigned ALU_SLL   = 8;
  localparam int unsigned ALU_SRL   = 9;
  localparam int unsigned ALU_SRA   = 10;
  localparam int unsigned ALU_LUI   = 11;
  localparam int unsigned ALU_MUL   = 12;
  localparam int unsigned ALU_MULH  = 13;
  localparam int unsigned ALU_MULHU = 14;
  localparam int unsigned ALU_DIV   = 15;
  localparam int unsigned ALU_MOD   = 16;
  localparam int unsigned ALU_DIVU  = 17;
  localparam int unsigned ALU_MODU  = 18;

  localparam logic [ALU_OP_WD-1:0] DIV_OP_MASK = 19'h78000;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Field order matches the ID stage's concatenation, MSB first.
  typedef struct packed {
    logic [ALU_OP_WD-1:0] alu_op;
    logic [31:0]          src1;
    logic [31:0]          src2;
    logic [31:0]          rkd;
    logic [31:0]          pc;
    logic [4:0]           dest;
    logic                 gr_we;
    logic                 mem_we;
    logic                 res_from_mem;
    logic [1:0]           mem_size;
    logic                 ld_uns;
  } ds_to_es_bus_t;

endpackage

// File: rtl/exe_store_fmt.sv
// Store formatting: byte-lane strobes from access size and low address bits,
// store data replicated across all lanes.
module exe_store_fmt
  import exe_stage_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rkd,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata
);

  always_comb begin
    o_wstrb = 4'hf;
    o_wdata = i_rkd;
    case (i_size)
      MEM_SIZE_B: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_rkd[7:0]}};
      end
      MEM_SIZE_H: begin
        o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_rkd[15:0]}};
      end
      default: begin
        o_wstrb = 4'hf;
        o_wdata = i_rkd;
      end
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute pipeline stage: holds the ID->EX bundle, drives the external ALU,
// absorbs multi-cycle divide latency and issues data-SRAM requests.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_allowin,
  input  logic                       ms_allowin,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ALU_OP_WD-1:0]       alu_op,
  output logic [31:0]                alu_src1,
  output logic [31:0]                alu_src2,
  input  logic [31:0]                alu_result,
  input  logic                       alu_div_ready_go,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  output logic                       es_fwd_valid,
  output logic [4:0]                 es_fwd_dest,
  output logic [31:0]                es_fwd_data,
  output logic                       es_fwd_block
);

  ds_to_es_bus_t r_ds;
  logic          r_es_valid;
  div_state_e    r_state;
  div_state_e    w_state_nxt;
  logic [31:0]   r_div_buf;
  logic          w_capture;
  logic          w_div_done;
  logic          w_is_div;
  logic          w_es_ready_go;
  logic          w_fire;
  logic [31:0]   w_result;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata;

  assign w_div_done    = (r_state == DIV_DONE);
  assign w_is_div      = |(r_ds.alu_op & DIV_OP_MASK);
  assign w_es_ready_go = ~w_is_div | w_div_done | alu_div_ready_go;
  assign es_allowin    = ~r_es_valid | (w_es_ready_go & ms_allowin);
  assign es_to_ms_valid = r_es_valid & w_es_ready_go;
  assign w_fire        = r_es_valid & w_es_ready_go & ms_allowin;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_es_valid <= 1'b0;
      r_ds       <= '0;
    end else if (es_allowin) begin
      r_es_valid <= ds_to_es_valid;
      if (ds_to_es_valid) r_ds <= ds_to_es_bus;
    end
  end

  // A divide leaving in the same cycle its result appears never enters DONE;
  // only a divide stalled by MEM captures into the buffer.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    unique case (r_state)
      DIV_IDLE, DIV_WAIT: begin
        if (r_es_valid && w_is_div) begin
          if (!alu_div_ready_go) begin
            w_state_nxt = DIV_WAIT;
          end else if (!ms_allowin) begin
            w_state_nxt = DIV_DONE;
            w_capture   = 1'b1;
          end else begin
            w_state_nxt = DIV_IDLE;
          end
        end else begin
          w_state_nxt = DIV_IDLE;
        end
      end
      DIV_DONE: if (ms_allowin) w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= DIV_IDLE;
      r_div_buf <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_div_buf <= alu_result;
    end
  end

  assign alu_op   = (r_es_valid && !w_div_done) ? r_ds.alu_op : '0;
  assign alu_src1 = r_ds.src1;
  assign alu_src2 = r_ds.src2;
  assign w_result = w_div_done ? r_div_buf : alu_result;

  assign es_to_ms_bus = {r_ds.res_from_mem, r_ds.gr_we, r_ds.dest, r_ds.ld_uns,
                         r_ds.mem_size, w_result, r_ds.pc};

  exe_store_fmt u_store_fmt (
    .i_size    (r_ds.mem_size),
    .i_addr_lo (alu_result[1:0]),
    .i_rkd     (r_ds.rkd),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata)
  );

  assign data_sram_en    = w_fire & (r_ds.mem_we | r_ds.res_from_mem);
  assign data_sram_we    = (w_fire && r_ds.mem_we) ? w_wstrb : 4'h0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = w_wdata;

  assign es_fwd_valid = r_es_valid & r_ds.gr_we & (r_ds.dest != 5'd0);
  assign es_fwd_dest  = r_ds.dest;
  assign es_fwd_data  = w_result;
  assign es_fwd_block = es_fwd_valid & (r_ds.res_from_mem | ~w_es_ready_go);

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with a small behavioural ALU model whose divides
// take DIV_LAT cycles.
module tb_exe_stage;
  import exe_stage_pkg::*;

  localparam int unsigned DIV_LAT = 3;
  localparam logic [31:0] PC0 = 32'h1c00_0040;

  logic         clk;
  logic         resetn;
  logic         ds_to_es_valid;
  logic [157:0] ds_to_es_bus;
  logic         es_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [73:0]  es_to_ms_bus;
  logic [18:0]  alu_op;
  logic [31:0]  alu_src1, alu_src2, alu_result;
  logic         alu_div_ready_go;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic         es_fwd_valid;
  logic [4:0]   es_fwd_dest;
  logic [31:0]  es_fwd_data;
  logic         es_fwd_block;

  int unsigned n_chk;
  int unsigned n_pass;

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_allowin      (es_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .alu_op          (alu_op),
    .alu_src1        (alu_src1),
    .alu_src2        (alu_src2),
    .alu_result      (alu_result),
    .alu_div_ready_go(alu_div_ready_go),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .es_fwd_valid    (es_fwd_valid),
    .es_fwd_dest     (es_fwd_dest),
    .es_fwd_data     (es_fwd_data),
    .es_fwd_block    (es_fwd_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: divide ops hold ready_go low for DIV_LAT cycles after they appear
  logic [3:0] div_cnt;
  logic       div_req;
  assign div_req = |(alu_op & DIV_OP_MASK);

  always_ff @(posedge clk) begin
    if (!resetn || !div_req) div_cnt <= '0;
    else if (div_cnt < 4'(DIV_LAT)) div_cnt <= div_cnt + 4'd1;
  end

  assign alu_div_ready_go = !div_req || (div_cnt == 4'(DIV_LAT));

  always_comb begin
    alu_result = '0;
    if (alu_op[ALU_ADD]) alu_result = alu_src1 + alu_src2;
    else if (alu_src2 != 32'd0) begin
      if (alu_op[ALU_DIV])       alu_result = $signed(alu_src1) / $signed(alu_src2);
      else if (alu_op[ALU_MOD])  alu_result = $signed(alu_src1) % $signed(alu_src2);
      else if (alu_op[ALU_DIVU]) alu_result = alu_src1 / alu_src2;
      else if (alu_op[ALU_MODU]) alu_result = alu_src1 % alu_src2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [157:0] mk(input int unsigned op, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] rkd,
                                      input logic [4:0] dest, input logic gr_we,
                                      input logic mem_we, input logic rfm,
                                      input logic [1:0] size);
    logic [18:0] onehot;
    onehot = 19'd1 << op;
    return {onehot, s1, s2, rkd, PC0, dest, gr_we, mem_we, rfm, size, 1'b0};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    resetn = 1'b0;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    ms_allowin = 1'b1;
    next(); next();
    #1;
    chk("rst_ms_valid", 32'(es_to_ms_valid), 32'd0);
    chk("rst_alu_op",   32'(alu_op), 32'd0);
    chk("rst_sram_en",  32'(data_sram_en), 32'd0);
    chk("rst_sram_we",  32'(data_sram_we), 32'd0);
    chk("rst_fwd",      32'({es_fwd_valid, es_fwd_block}), 32'd0);
    resetn = 1'b1;

    // add 5+7
    next();
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(ALU_ADD, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, MEM_SIZE_W);
    #1;
    chk("add_allowin_empty", 32'(es_allowin), 32'd1);
    next();
    ds_to_es_valid = 1'b0;
    #1;
    chk("add_ms_valid", 32'(es_to_ms_valid), 32'd1);
    chk("add_result",   es_to_ms_bus[63:32], 32'd12);
    chk("add_pc",       es_to_ms_bus[31:0], PC0);
    chk("add_allowin",  32'(es_allowin), 32'd1);
    chk("add_fwd",      {25'd0, es_fwd_valid, es_fwd_block, es_fwd_dest}, {25'd0, 2'b10, 5'd3});
    chk("add_fwd_data", es_fwd_data, 32'd12);
    chk("add_no_mem",   32'(data_sram_en), 32'd0);
    next(); #1;
    chk("add_drain", 32'(es_to_ms_valid), 32'd0);

    // back-to-back: second accepted in the cycle the first leaves
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(ALU_ADD, 32'd1, 32'd2, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, MEM_SIZE_W);
    next();
    ds_to_es_bus = mk(ALU_ADD, 32'd100, 32'd200, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, MEM_SIZE_W);
    #1;
    chk("b2b_first", es_to_ms_bus[63:32], 32'd3);
    chk("b2b_allowin", 32'(es_allowin), 32'd1);
    next();
    ds_to_es_valid = 1'b0;
    #1;
    chk("b2b_second", es_to_ms_bus[63:32], 32'd300);
    chk("b2b_dest", 32'(es_to_ms_bus[71:67]), 32'd7);
    next();

    // div.w -7/2
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, MEM_SIZE_W);
    next();
    ds_to_es_valid = 1'b0;
    #1;
    for (int k = 0; k < int'(DIV_LAT); k++) begin
      chk("div_allowin_stall", 32'(es_allowin), 32'd0);
      chk("div_fwd_block", 32'(es_fwd_block), 32'd1);
      chk("div_alu_op", 32'(alu_op), 32'h0000_8000);
      next(); #1;
    end
    chk("div_ms_valid", 32'(es_to_ms_valid), 32'd1);
    chk("div_result", es_to_ms_bus[63:32], 32'hFFFF_FFFD);
    chk("div_block_clear", 32'(es_fwd_block), 32'd0);
    next(); #1;
    chk("div_op_off", 32'(alu_op), 32'd0);
    chk("div_drain", 32'(es_to_ms_valid), 32'd0);

    // mod.wu 10/3 with MEM stalled past the result
    ds_to_es_valid = 1'b1;
    ms_allowin = 1'b0;
    ds_to_es_bus = mk(ALU_MODU, 32'd10, 32'd3, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, MEM_SIZE_W);
    next();
    ds_to_es_valid = 1'b0;
    #1;
    for (int k = 0; k < int'(DIV_LAT); k++) begin
      next(); #1;
    end
    chk("mod_ready", 32'(es_to_ms_valid), 32'd1);
    chk("mod_result_bypass", es_to_ms_bus[63:32], 32'd1);
    for (int h = 0; h < 5; h++) begin
      next(); #1;
      chk("mod_hold_op", 32'(alu_op), 32'd0);
      chk("mod_hold_result", es_to_ms_bus[63:32], 32'd1);
      chk("mod_hold_valid", 32'(es_to_ms_valid), 32'd1);
      chk("mod_hold_allowin", 32'(es_allowin), 32'd0);
    end
    ms_allowin = 1'b1;
    #1;
    chk("mod_release_allowin", 32'(es_allowin), 32'd1);
    chk("mod_release_result", es_to_ms_bus[63:32], 32'd1);
    next(); #1;
    chk("mod_no_restart", 32'(alu_op), 32'd0);
    chk("mod_drain", 32'(es_to_ms_valid), 32'd0);

    // st.b at 0x1003
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(ALU_ADD, 32'h1000, 32'd3, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0, MEM_SIZE_B);
    next();
    ds_to_es_valid = 1'b0;
    #1;
    chk("stb_en", 32'(data_sram_en), 32'd1);
    chk("stb_we", 32'(data_sram_we), 32'h8);
    chk("stb_wdata", data_sram_wdata, 32'h7878_7878);
    chk("stb_addr", data_sram_addr, 32'h1003);
    next(); #1;
    chk("stb_once_en", 32'(data_sram_en), 32'd0);
    chk("stb_once_we", 32'(data_sram_we), 32'd0);

    // st.h at 0x1002
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(ALU_ADD, 32'h1000, 32'd2, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0, MEM_SIZE_H);
    next();
    ds_to_es_valid = 1'b0;
    #1;
    chk("sth_we", 32'(data_sram_we), 32'hC);
    chk("sth_wdata", data_sram_wdata, 32'h5678_5678);
    next();

    // st.w held by MEM for one cycle
    ds_to_es_valid = 1'b1;
    ms_allowin = 1'b0;
    ds_to_es_bus = mk(ALU_ADD, 32'h2000, 32'd0, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 1'b0, MEM_SIZE_W);
    next();
    ds_to_es_valid = 1'b0;
    #1;
    chk("stw_hold_en", 32'(data_sram_en), 32'd0);
    chk("stw_hold_we", 32'(data_sram_we), 32'd0);
    ms_allowin = 1'b1;
    #1;
    chk("stw_en", 32'(data_sram_en), 32'd1);
    chk("stw_we", 32'(data_sram_we), 32'hF);
    chk("stw_wdata", data_sram_wdata, 32'hCAFE_F00D);
    next(); #1;
    chk("stw_once", 32'(data_sram_en), 32'd0);

    // ld.w to r4
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(ALU_ADD, 32'h3000, 32'd4, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, MEM_SIZE_W);
    next();
    ds_to_es_valid = 1'b0;
    #1;
    chk("ld_fwd", {25'd0, es_fwd_valid, es_fwd_block, es_fwd_dest}, {25'd0, 2'b11, 5'd4});
    chk("ld_en_we", {27'd0, data_sram_en, data_sram_we}, {27'd0, 1'b1, 4'h0});
    chk("ld_rfm_bit", 32'(es_to_ms_bus[73]), 32'd1);
    next();

    // write to r0 is not forwarded
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(ALU_ADD, 32'd9, 32'd9, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, MEM_SIZE_W);
    next();
    ds_to_es_valid = 1'b0;
    #1;
    chk("r0_fwd_valid", 32'(es_fwd_valid), 32'd0);
    next();

    // reset during divide wait
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(ALU_DIV, 32'd100, 32'd7, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, MEM_SIZE_W);
    next();
    ds_to_es_valid = 1'b0;
    next(); #1;
    chk("rdiv_waiting", 32'(es_allowin), 32'd0);
    resetn = 1'b0;
    next();
    resetn = 1'b1;
    #1;
    chk("rdiv_ms_valid", 32'(es_to_ms_valid), 32'd0);
    chk("rdiv_alu_op", 32'(alu_op), 32'd0);
    chk("rdiv_sram_en", 32'(data_sram_en), 32'd0);
    chk("rdiv_allowin", 32'(es_allowin), 32'd1);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(ALU_ADD, 32'd20, 32'd22, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, MEM_SIZE_W);
    next();
    ds_to_es_valid = 1'b0;
    #1;
    chk("rdiv_fresh_valid", 32'(es_to_ms_valid), 32'd1);
    chk("rdiv_fresh_result", es_to_ms_bus[63:32], 32'd42);
    next();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
